// File: rtl/result_display.sv
// Reaction-tester result display: sequential double-dabble BCD conversion of res,
// then 4-digit multiplexed common-anode seven-segment scan. Optional macro: RESULT_DISPLAY_LZB_EN.
module result_display #(
    parameter int FREQ    = 100_000_000,
    parameter int SCAN_HZ = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] res,
    input  logic       hint,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       busy
);

    localparam int SCAN_DIV = FREQ / SCAN_HZ;
    localparam int PW       = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic          load_s, shift_s, done_s;
    logic [8:0]    shadow_r, bin_r;
    logic [11:0]   bcd_r, adj_s;
    logic [20:0]   shifted_s;
    logic [3:0]    cnt_r;
    logic [3:0]    dig2_r, dig1_r, dig0_r;
    logic          busy_r;
    logic [PW-1:0] presc_r;
    logic [1:0]    idx_r;
    logic          dash_s;
    logic [6:0]    sel_s;
    logic [6:0]    seg_r;
    logic [3:0]    an_r;
    logic          dp_r;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Adjust-then-shift step; the hundreds nibble never overflows for a 9-bit input.
    assign adj_s     = {add3(bcd_r[11:8]), add3(bcd_r[7:4]), add3(bcd_r[3:0])};
    assign shifted_s = 21'({adj_s, bin_r, 1'b0});
    assign dash_s    = hint;

    // Conversion FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_s;
    end

    // Conversion FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (res != shadow_r) state_s = SHIFT; else state_s = IDLE;
            SHIFT:   if (cnt_r == 4'd8) state_s = DONE; else state_s = SHIFT;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Conversion FSM control strobes
    always_comb begin
        load_s  = 1'b0;
        shift_s = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            IDLE:    load_s  = (res != shadow_r);
            SHIFT:   shift_s = 1'b1;
            DONE:    done_s  = 1'b1;
            default: load_s  = 1'b0;
        endcase
    end

    // Conversion datapath: capture, shift iterations, digit write-back
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_r <= 9'd0;
            bin_r    <= 9'd0;
            bcd_r    <= 12'h000;
            cnt_r    <= 4'd0;
            dig2_r   <= 4'd0;
            dig1_r   <= 4'd0;
            dig0_r   <= 4'd0;
            busy_r   <= 1'b0;
        end else if (load_s) begin
            shadow_r <= res;
            bin_r    <= res;
            bcd_r    <= 12'h000;
            cnt_r    <= 4'd0;
            busy_r   <= 1'b1;
        end else if (shift_s) begin
            {bcd_r, bin_r} <= shifted_s;
            cnt_r          <= cnt_r + 4'd1;
        end else if (done_s) begin
            {dig2_r, dig1_r, dig0_r} <= bcd_r;
            busy_r                   <= 1'b0;
        end
    end

    // Scan prescaler and digit index
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= '0;
            idx_r   <= 2'd0;
        end else if (presc_r == PRESC_LAST) begin
            presc_r <= '0;
            idx_r   <= idx_r + 2'd1;
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    // Glyph for the currently selected digit
    always_comb begin
        sel_s = SEG_BLANK;
        if (dash_s) begin
            sel_s = SEG_DASH;
        end else begin
            case (idx_r)
                2'd0: sel_s = glyph(dig0_r);
`ifdef RESULT_DISPLAY_LZB_EN
                2'd1: if ((dig2_r == 4'd0) && (dig1_r == 4'd0)) sel_s = SEG_BLANK; else sel_s = glyph(dig1_r);
                2'd2: if (dig2_r == 4'd0) sel_s = SEG_BLANK; else sel_s = glyph(dig2_r);
`else
                2'd1: sel_s = glyph(dig1_r);
                2'd2: sel_s = glyph(dig2_r);
`endif
                default: sel_s = SEG_BLANK;
            endcase
        end
    end

    // Registered display outputs; anode and glyph update on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_r <= 7'h7F;
            an_r  <= 4'hF;
            dp_r  <= 1'b1;
        end else begin
            seg_r <= sel_s;
            an_r  <= ~(4'b0001 << idx_r);
            dp_r  <= 1'b1;
        end
    end

    assign seg  = seg_r;
    assign an   = an_r;
    assign dp   = dp_r;
    assign busy = busy_r;

endmodule
